if_fetch_stage: RTL and testbench
=================================

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on posedge clk.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port preif_to_if_valid_i, input, 1, pre-IF offers nextpc this cycle.
REQ-004 SHALL have port nextpc_i, input, 32, PC offered by pre-IF.
REQ-005 SHALL have port if_allowin_o, output, 1, IF accepts nextpc this cycle.
REQ-006 SHALL have port if_pc_o, output, 32, current IF PC, fed back to pre-IF as its base PC.
REQ-007 SHALL have port flush_i, input, 1, exception/ertn redirect this cycle.
REQ-008 SHALL have port inst_sram_en_o, input-side request enable, output, 1.
REQ-009 SHALL have port inst_sram_addr_o, output, 32, fetch address.
REQ-010 SHALL have port inst_sram_rdata_i, input, 32, read data, valid exactly one cycle after the request.
REQ-011 SHALL have port id_allowin_i, input, 1, ID accepts this cycle.
REQ-012 SHALL have port if_to_id_valid_o, output, 1, IF holds a valid instruction for ID.
REQ-013 SHALL have port if_to_id_bus_o, output, 65, {adef, pc[31:0], inst[31:0]}.

Function
REQ-014 SHALL compute if_allowin_o = !if_valid | id_allowin_i | flush_i (IF ready_go is constant 1).
REQ-015 SHALL define accept = preif_to_if_valid_i & if_allowin_o; on accept, next cycle if_valid=1 and if_pc=nextpc_i.
REQ-016 SHALL drive inst_sram_en_o = accept & (nextpc_i[1:0]==2'b00) and inst_sram_addr_o = nextpc_i, combinationally, same cycle as accept.
REQ-017 SHALL, without accept, hold if_pc; if_valid clears when IF->ID transfer occurs (if_valid & id_allowin_i) or flush_i.
REQ-018 SHALL track fresh=1 for exactly the cycle after an accept (rdata_i valid).
REQ-019 SHALL, when fresh & !id_allowin_i & !flush_i, capture inst_sram_rdata_i into inst_buf and set buf_valid=1.
REQ-020 SHALL output inst = buf_valid ? inst_buf : inst_sram_rdata_i; buffered word stays stable for any stall length.
REQ-021 SHALL clear buf_valid on IF->ID transfer, on flush_i, and on accept.
REQ-022 SHALL set adef = (if_pc[1:0]!=0); when adef=1, inst field = 32'h0 and no SRAM request was issued.
REQ-023 SHALL drive if_to_id_valid_o = if_valid & !flush_i.
REQ-024 SHALL, on flush_i with simultaneous preif valid, accept the redirect PC (flush wins over stall); old instruction and buffer discarded.
REQ-025 SHALL give fetch latency of 1 cycle: PC accepted in cycle N appears on if_to_id_bus_o in cycle N+1.
REQ-026 SHALL sustain one instruction per cycle when id_allowin_i stays 1.

Reset
REQ-027 SHALL, on rst, set if_valid=0, buf_valid=0, fresh=0, inst_buf=0, if_pc=32'h1BFF_FFFC (first fetch 32'h1C00_0000).
REQ-028 SHALL, during rst, force inst_sram_en_o=0, if_allowin_o=0; outputs reset values regardless of in-flight fetch.

Structure
REQ-029 SHALL take bus width IfToIdBusWidth (65) and reset PC constant from the shared define header.
REQ-030 SHALL be one flat module; the inst_buf/buf_valid hold logic MAY be a sub-module if_inst_buf.

Verification
REQ-031 Reset release, preif valid, id_allowin=1 -> SRAM addr 1C000000 then 1C000004, 1C000008 back-to-back; bus pc/inst match one cycle later.
REQ-032 id_allowin=0 for 3 cycles after fetch of 1C000004 (rdata=0x02800421, then garbage) -> inst held 0x02800421, no new SRAM request, if_pc_o stays 1C000004.
REQ-033 flush_i with nextpc=1C008000 while IF stalled holding 1C000010 -> next cycle if_pc=1C008000, buffer cleared, old inst never valid to ID.
REQ-034 nextpc=1C000002 accepted -> inst_sram_en_o=0, next cycle bus adef=1, inst=0.
REQ-035 rst asserted mid-stall with buf_valid=1 -> next cycle if_valid=0, buf_valid=0, if_pc=1BFFFFFC.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// The IF->ID bus layout is defined here once so producer and consumer agree.
package if_fetch_stage_pkg;

  localparam int unsigned XLen           = 32;
  localparam int unsigned IfToIdBusWidth = 65;
  localparam logic [31:0] ResetPc        = 32'h1BFF_FFFC;

  typedef struct packed {
    logic            adef;
    logic [XLen-1:0] pc;
    logic [XLen-1:0] inst;
  } if_to_id_bus_t;

  function automatic logic pc_misaligned(input logic [XLen-1:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction SRAM request/response bus between the fetch stage and the SRAM.
// Read data returns exactly one cycle after an enabled request.
interface if_fetch_stage_if;
  import if_fetch_stage_pkg::*;

  logic            inst_sram_en_o;
  logic [XLen-1:0] inst_sram_addr_o;
  logic [XLen-1:0] inst_sram_rdata_i;

  modport master (
    output inst_sram_en_o,
    output inst_sram_addr_o,
    input  inst_sram_rdata_i
  );

  modport slave (
    input  inst_sram_en_o,
    input  inst_sram_addr_o,
    output inst_sram_rdata_i
  );

endinterface

// File: rtl/if_fetch_stage_inst_buf.sv
// Holds the SRAM read word while ID stalls, so the instruction stays stable
// after the one-cycle SRAM data window has passed.
module if_fetch_stage_inst_buf
  import if_fetch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            capture_i,
  input  logic            clear_i,
  input  logic [XLen-1:0] rdata_i,
  output logic [XLen-1:0] inst_o
);

  logic            buf_valid_q, buf_valid_d;
  logic [XLen-1:0] inst_buf_q, inst_buf_d;

  always_comb begin
    buf_valid_d = buf_valid_q;
    inst_buf_d  = inst_buf_q;
    if (clear_i) begin
      buf_valid_d = 1'b0;
    end else if (capture_i) begin
      buf_valid_d = 1'b1;
      inst_buf_d  = rdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      inst_buf_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      inst_buf_q  <= inst_buf_d;
    end
  end

  assign inst_o = buf_valid_q ? inst_buf_q : rdata_i;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: accepts a PC from pre-IF, issues the SRAM read,
// and presents {adef, pc, inst} to ID one cycle later, buffering across stalls.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      preif_to_if_valid_i,
  input  logic [XLen-1:0]           nextpc_i,
  output logic                      if_allowin_o,
  output logic [XLen-1:0]           if_pc_o,
  input  logic                      flush_i,
  if_fetch_stage_if.master          sram,
  input  logic                      id_allowin_i,
  output logic                      if_to_id_valid_o,
  output logic [IfToIdBusWidth-1:0] if_to_id_bus_o
);

  logic            if_valid_q, if_valid_d;
  logic            fresh_q, fresh_d;
  logic [XLen-1:0] if_pc_q, if_pc_d;
  logic            accept;
  logic            transfer;
  logic            adef;
  logic [XLen-1:0] inst_raw;
  if_to_id_bus_t   bus;

  // Reset gates the handshake combinationally so nothing is requested mid-reset.
  assign if_allowin_o = !rst && (!if_valid_q || id_allowin_i || flush_i);
  assign accept       = preif_to_if_valid_i && if_allowin_o;
  assign transfer     = if_valid_q && id_allowin_i;

  assign sram.inst_sram_en_o   = accept && !pc_misaligned(nextpc_i);
  assign sram.inst_sram_addr_o = nextpc_i;

  always_comb begin
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    fresh_d    = accept;
    if (accept) begin
      if_valid_d = 1'b1;
      if_pc_d    = nextpc_i;
    end else if (transfer || flush_i) begin
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid_q <= 1'b0;
      fresh_q    <= 1'b0;
      if_pc_q    <= ResetPc;
    end else begin
      if_valid_q <= if_valid_d;
      fresh_q    <= fresh_d;
      if_pc_q    <= if_pc_d;
    end
  end

  if_fetch_stage_inst_buf u_inst_buf (
    .clk       (clk),
    .rst       (rst),
    .capture_i (fresh_q && !id_allowin_i && !flush_i),
    .clear_i   (transfer || flush_i || accept),
    .rdata_i   (sram.inst_sram_rdata_i),
    .inst_o    (inst_raw)
  );

  // A misaligned PC never issued a read, so its inst field is forced to zero.
  assign adef     = pc_misaligned(if_pc_q);
  assign bus.adef = adef;
  assign bus.pc   = if_pc_q;
  assign bus.inst = adef ? '0 : inst_raw;

  assign if_pc_o          = if_pc_q;
  assign if_to_id_valid_o = if_valid_q && !flush_i && !rst;
  assign if_to_id_bus_o   = bus;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a per-cycle vector table plus hand-written
// long-stall and flush-without-redirect sequences.
module tb_if_fetch_stage;
  import if_fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        preif_to_if_valid_i;
  logic [31:0] nextpc_i;
  logic        if_allowin_o;
  logic [31:0] if_pc_o;
  logic        flush_i;
  logic        id_allowin_i;
  logic        if_to_id_valid_o;
  logic [64:0] if_to_id_bus_o;

  if_fetch_stage_if sram_bus ();

  if_fetch_stage dut (
    .clk                 (clk),
    .rst                 (rst),
    .preif_to_if_valid_i (preif_to_if_valid_i),
    .nextpc_i            (nextpc_i),
    .if_allowin_o        (if_allowin_o),
    .if_pc_o             (if_pc_o),
    .flush_i             (flush_i),
    .sram                (sram_bus),
    .id_allowin_i        (id_allowin_i),
    .if_to_id_valid_o    (if_to_id_valid_o),
    .if_to_id_bus_o      (if_to_id_bus_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        pv;
    logic [31:0] npc;
    logic        fl;
    logic [31:0] rd;
    logic        ida;
    logic        e_allow;
    logic        e_en;
    logic        chk_pc;
    logic [31:0] e_pc;
    logic        e_v;
    logic        chk_bus;
    logic [64:0] e_bus;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic vec_t mk(logic r, logic pv, logic [31:0] npc, logic fl,
                              logic [31:0] rd, logic ida, logic e_allow,
                              logic e_en, logic chk_pc, logic [31:0] e_pc,
                              logic e_v, logic chk_bus, logic [64:0] e_bus);
    vec_t v;
    v.rst = r; v.pv = pv; v.npc = npc; v.fl = fl; v.rd = rd; v.ida = ida;
    v.e_allow = e_allow; v.e_en = e_en; v.chk_pc = chk_pc; v.e_pc = e_pc;
    v.e_v = e_v; v.chk_bus = chk_bus; v.e_bus = e_bus;
    return v;
  endfunction

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic pv, input logic [31:0] npc,
                       input logic fl, input logic [31:0] rd, input logic ida);
    rst = r; preif_to_if_valid_i = pv; nextpc_i = npc; flush_i = fl;
    sram_bus.inst_sram_rdata_i = rd; id_allowin_i = ida;
  endtask

  initial begin
    //            rst pv npc           fl rd            ida allow en chkpc pc           v  chkbus bus
    vecs.push_back(mk(1, 1, 32'h1C000000, 0, 32'h00000000, 1, 0, 0, 1, 32'h1BFFFFFC, 0, 0, 65'h0));
    vecs.push_back(mk(0, 1, 32'h1C000000, 0, 32'h00000000, 1, 1, 1, 1, 32'h1BFFFFFC, 0, 0, 65'h0));
    vecs.push_back(mk(0, 1, 32'h1C000004, 0, 32'h11111111, 1, 1, 1, 1, 32'h1C000000, 1, 1, {1'b0, 32'h1C000000, 32'h11111111}));
    vecs.push_back(mk(0, 1, 32'h1C000008, 0, 32'h02800421, 0, 0, 0, 1, 32'h1C000004, 1, 1, {1'b0, 32'h1C000004, 32'h02800421}));
    vecs.push_back(mk(0, 1, 32'h1C000008, 0, 32'hDEADBEEF, 0, 0, 0, 1, 32'h1C000004, 1, 1, {1'b0, 32'h1C000004, 32'h02800421}));
    vecs.push_back(mk(0, 1, 32'h1C000008, 0, 32'hCAFEF00D, 0, 0, 0, 1, 32'h1C000004, 1, 1, {1'b0, 32'h1C000004, 32'h02800421}));
    vecs.push_back(mk(0, 1, 32'h1C000008, 0, 32'h12345678, 1, 1, 1, 1, 32'h1C000004, 1, 1, {1'b0, 32'h1C000004, 32'h02800421}));
    vecs.push_back(mk(0, 1, 32'h1C00000C, 0, 32'h0000AAAA, 1, 1, 1, 1, 32'h1C000008, 1, 1, {1'b0, 32'h1C000008, 32'h0000AAAA}));
    vecs.push_back(mk(0, 1, 32'h1C000010, 0, 32'h0000BBBB, 1, 1, 1, 1, 32'h1C00000C, 1, 1, {1'b0, 32'h1C00000C, 32'h0000BBBB}));
    vecs.push_back(mk(0, 1, 32'h1C000014, 0, 32'h0000CCCC, 0, 0, 0, 1, 32'h1C000010, 1, 1, {1'b0, 32'h1C000010, 32'h0000CCCC}));
    vecs.push_back(mk(0, 1, 32'h1C008000, 1, 32'h99999999, 0, 1, 1, 1, 32'h1C000010, 0, 0, 65'h0));
    vecs.push_back(mk(0, 0, 32'h00000000, 0, 32'h44444444, 0, 0, 0, 1, 32'h1C008000, 1, 1, {1'b0, 32'h1C008000, 32'h44444444}));
    vecs.push_back(mk(0, 1, 32'h1C000002, 0, 32'h55555555, 1, 1, 0, 1, 32'h1C008000, 1, 1, {1'b0, 32'h1C008000, 32'h44444444}));
    vecs.push_back(mk(0, 0, 32'h00000000, 0, 32'h66666666, 0, 0, 0, 1, 32'h1C000002, 1, 1, {1'b1, 32'h1C000002, 32'h00000000}));
    vecs.push_back(mk(0, 1, 32'h1C008004, 0, 32'h77777777, 0, 0, 0, 1, 32'h1C000002, 1, 1, {1'b1, 32'h1C000002, 32'h00000000}));
    vecs.push_back(mk(0, 1, 32'h1C008004, 0, 32'h88888888, 1, 1, 1, 1, 32'h1C000002, 1, 1, {1'b1, 32'h1C000002, 32'h00000000}));
    vecs.push_back(mk(0, 1, 32'h1C008008, 0, 32'hABCD0001, 0, 0, 0, 1, 32'h1C008004, 1, 1, {1'b0, 32'h1C008004, 32'hABCD0001}));
    vecs.push_back(mk(0, 1, 32'h1C008008, 0, 32'h0BAD0BAD, 0, 0, 0, 1, 32'h1C008004, 1, 1, {1'b0, 32'h1C008004, 32'hABCD0001}));
    vecs.push_back(mk(1, 1, 32'h1C008008, 0, 32'h00000000, 1, 0, 0, 0, 32'h00000000, 0, 0, 65'h0));
    vecs.push_back(mk(0, 0, 32'h00000000, 0, 32'h13572468, 0, 1, 0, 1, 32'h1BFFFFFC, 0, 1, {1'b0, 32'h1BFFFFFC, 32'h13572468}));
    vecs.push_back(mk(0, 1, 32'h1C000000, 0, 32'h00000000, 1, 1, 1, 1, 32'h1BFFFFFC, 0, 1, {1'b0, 32'h1BFFFFFC, 32'h00000000}));

    drive(1, 0, 32'h0, 0, 32'h0, 0);
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].pv, vecs[i].npc, vecs[i].fl, vecs[i].rd, vecs[i].ida);
      @(negedge clk);
      check($sformatf("row%0d allowin", i), {64'h0, if_allowin_o}, {64'h0, vecs[i].e_allow});
      check($sformatf("row%0d sram_en", i), {64'h0, sram_bus.inst_sram_en_o}, {64'h0, vecs[i].e_en});
      check($sformatf("row%0d to_id_valid", i), {64'h0, if_to_id_valid_o}, {64'h0, vecs[i].e_v});
      if (vecs[i].e_en)
        check($sformatf("row%0d sram_addr", i), {33'h0, sram_bus.inst_sram_addr_o}, {33'h0, vecs[i].npc});
      if (vecs[i].chk_pc)
        check($sformatf("row%0d if_pc", i), {33'h0, if_pc_o}, {33'h0, vecs[i].e_pc});
      if (vecs[i].chk_bus)
        check($sformatf("row%0d bus", i), if_to_id_bus_o, vecs[i].e_bus);
      @(posedge clk);
      #1;
    end

    // Long stall: the word captured in the data cycle must survive SRAM garbage.
    drive(0, 1, 32'h1C000004, 0, 32'h0F0F0F0F, 0);
    @(negedge clk);
    check("stall first bus", if_to_id_bus_o, {1'b0, 32'h1C000000, 32'h0F0F0F0F});
    check("stall first allowin", {64'h0, if_allowin_o}, 65'h0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 10; k++) begin
      sram_bus.inst_sram_rdata_i = $urandom;
      @(negedge clk);
      check($sformatf("stall%0d bus", k), if_to_id_bus_o, {1'b0, 32'h1C000000, 32'h0F0F0F0F});
      check($sformatf("stall%0d sram_en", k), {64'h0, sram_bus.inst_sram_en_o}, 65'h0);
      @(posedge clk);
      #1;
    end

    // Flush with no redirect offered: IF empties and the buffer is dropped.
    drive(0, 0, 32'h0, 1, 32'h0, 0);
    @(negedge clk);
    check("flush to_id_valid", {64'h0, if_to_id_valid_o}, 65'h0);
    check("flush allowin", {64'h0, if_allowin_o}, 65'h1);
    @(posedge clk);
    #1;
    drive(0, 0, 32'h0, 0, 32'h5A5A5A5A, 0);
    @(negedge clk);
    check("postflush to_id_valid", {64'h0, if_to_id_valid_o}, 65'h0);
    check("postflush allowin", {64'h0, if_allowin_o}, 65'h1);
    check("postflush bus", if_to_id_bus_o, {1'b0, 32'h1C000000, 32'h5A5A5A5A});
    @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
